// File: rtl/digit_pkg.sv
// Shared types and constants for the digit stream encoder.
package digit_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    localparam int unsigned MAG_MAX      = 31;
    localparam int unsigned BCD_MAX      = 9;
    localparam int unsigned DIGIT_CODE_W = 5;
    localparam int unsigned POS_FLAG_BIT = 4;

endpackage

// File: rtl/digit_mac.sv
// Combinational decimal multiply-accumulate: acc*10 + digit, saturating at the magnitude limit.
module digit_mac
    import digit_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic [W-2:0] acc_i,
    input  logic [3:0]   digit_i,
    output logic [W-2:0] result_o,
    output logic         ovf_o,
    output logic         bad_digit_o
);

    // Wide enough that 10*max_mag + 15 cannot wrap.
    localparam int unsigned IW = W + 4;
    localparam logic [IW-1:0] MagMax = IW'((2 ** (W - 1)) - 1);

    logic [IW-1:0] sum;

    // Accumulate, then pick saturated, unchanged or raw result.
    always_comb begin
        sum         = IW'(acc_i) * IW'(10) + IW'(digit_i);
        bad_digit_o = (digit_i > 4'(BCD_MAX));
        ovf_o       = !bad_digit_o && (sum > MagMax);
        if (bad_digit_o) begin
            result_o = acc_i;
        end else if (ovf_o) begin
            result_o = MagMax[W-2:0];
        end else begin
            result_o = sum[W-2:0];
        end
    end

endmodule

// File: rtl/digit_stream_encoder.sv
// Rebuilds a signed sign/one's-complement value from an MSD-first stream of digit codes.
module digit_stream_encoder
    import digit_pkg::*;
#(
    parameter int unsigned W          = 6,
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGIT_CODE_W-1:0] in_digit,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_value,
    output logic                    out_err
);

    // Counter must be able to hold MAX_DIGITS+1 without wrapping.
    localparam int unsigned CntW = $clog2(MAX_DIGITS + 2);

    state_e          state_q, state_d;
    logic [W-2:0]    acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic            err_q, err_d;
    logic [W-1:0]    out_value_q, out_value_d;
    logic            out_err_q, out_err_d;

    logic            accept;
    logic            take;
    logic [W-2:0]    mac_acc;
    logic [W-2:0]    mac_result;
    logic            mac_ovf;
    logic            mac_bad;

    digit_mac #(
        .W (W)
    ) u_mac (
        .acc_i       (mac_acc),
        .digit_i     (in_digit[3:0]),
        .result_o    (mac_result),
        .ovf_o       (mac_ovf),
        .bad_digit_o (mac_bad)
    );

    // Next-state, accumulator update and output staging.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        err_d       = err_q;
        out_value_d = out_value_q;
        out_err_d   = out_err_q;
        take        = 1'b0;

        in_ready  = (state_q != StDone);
        out_valid = (state_q == StDone);
        accept    = in_valid && in_ready;
        // A first beat starts from zero so the MAC yields the digit itself.
        mac_acc   = in_first ? '0 : acc_q;

        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    if (in_first) begin
                        take   = 1'b1;
                        sign_d = ~in_digit[POS_FLAG_BIT];
                        cnt_d  = CntW'(1);
                        acc_d  = mac_result;
                        err_d  = mac_bad || mac_ovf;
                    end else if (state_q == StAccum) begin
                        take = 1'b1;
                        if (cnt_q != CntW'(MAX_DIGITS + 1)) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                        if (cnt_q >= CntW'(MAX_DIGITS)) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d = mac_result;
                            if (mac_bad || mac_ovf) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                    // Non-first beats in idle are dropped silently.
                    if (take) begin
                        if (in_last) begin
                            state_d     = StDone;
                            out_value_d = {sign_d, sign_d ? ~acc_d : acc_d};
                            out_err_d   = err_d;
                        end else begin
                            state_d = StAccum;
                        end
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            out_value_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            err_q       <= err_d;
            out_value_q <= out_value_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_value = out_value_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_digit_stream_encoder.sv
// Directed self-checking bench for digit_stream_encoder.
module tb_digit_stream_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_digit;
    logic       in_first;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_value;
    logic       out_err;

    int checks;
    int failures;

    digit_stream_encoder #(
        .W          (6),
        .MAX_DIGITS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One accepted-or-offered beat; returns #1 after the sampling edge.
    task automatic beat(input logic [4:0] d, input logic f, input logic l);
        in_digit = d;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [5:0] val, input logic err);
        check({tag, "_valid"}, 8'(out_valid), 8'd1);
        check({tag, "_value"}, 8'(out_value), 8'(val));
        check({tag, "_err"}, 8'(out_err), 8'(err));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_digit  = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        #3;
        check("rst_valid", 8'(out_valid), 8'd0);
        check("rst_value", 8'(out_value), 8'd0);
        check("rst_err", 8'(out_err), 8'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("idle_ready", 8'(in_ready), 8'd1);

        // +27
        beat(5'b1_0010, 1'b1, 1'b0);
        check("accum_ready", 8'(in_ready), 8'd1);
        check("accum_valid", 8'(out_valid), 8'd0);
        beat(5'b1_0111, 1'b0, 1'b1);
        check_out("p27", 6'b011011, 1'b0);
        check("p27_ready", 8'(in_ready), 8'd0);
        step();
        check("p27_drop_valid", 8'(out_valid), 8'd0);

        // -19
        beat(5'b0_0001, 1'b1, 1'b0);
        beat(5'b0_1001, 1'b0, 1'b1);
        check_out("n19", 6'b101100, 1'b0);
        step();

        // +45 saturates, then +3 clears err
        beat(5'b1_0100, 1'b1, 1'b0);
        beat(5'b1_0101, 1'b0, 1'b1);
        check_out("sat45", 6'b011111, 1'b1);
        step();
        beat(5'b1_0011, 1'b1, 1'b1);
        check_out("p3", 6'b000011, 1'b0);
        step();

        // Bad BCD digit on first beat
        beat(5'b1_1100, 1'b1, 1'b0);
        beat(5'b1_0001, 0, 1'b1);
        check_out("badbcd", 6'b000001, 1'b1);
        step();

        // Fourth digit exceeds MAX_DIGITS: flagged, acc unchanged
        beat(5'b1_0000, 1'b1, 1'b0);
        beat(5'b1_0000, 1'b0, 1'b0);
        beat(5'b1_0001, 1'b0, 1'b0);
        beat(5'b1_0010, 1'b0, 1'b1);
        check_out("toomany", 6'b000001, 1'b1);
        step();

        // Backpressure
        out_ready = 1'b0;
        beat(5'b1_0010, 1'b1, 1'b0);
        beat(5'b1_0111, 1'b0, 1'b1);
        in_digit = 5'b1_0101;
        in_first = 1'b1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("bp_hold", 6'b011011, 1'b0);
            check("bp_ready", 8'(in_ready), 8'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 8'(out_valid), 8'd0);
        check("bp_release_ready", 8'(in_ready), 8'd1);
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        check_out("bp_new", 6'b000101, 1'b0);
        step();

        // Restart with in_first during ACCUM
        beat(5'b1_0001, 1'b1, 1'b0);
        beat(5'b1_0010, 1'b0, 1'b0);
        beat(5'b1_0111, 1'b1, 1'b1);
        check_out("restart", 6'b000111, 1'b0);
        step();

        // Async reset mid-ACCUM
        beat(5'b1_0001, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 8'(out_valid), 8'd0);
        check("midrst_value", 8'(out_value), 8'd0);
        check("midrst_err", 8'(out_err), 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        // The discarded number must not continue: a non-first beat is dropped.
        beat(5'b1_0011, 1'b0, 1'b1);
        check("postrst_drop", 8'(out_valid), 8'd0);
        beat(5'b0_0000, 1'b1, 1'b1);
        check_out("negzero", 6'b111111, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_stream_encoder.md
Name: digit_stream_encoder

Overview:
- Reverse direction of the signed-value-to-most-significant-digit decoder used in the same datapath.
- Accepts a stream of decimal digits, most significant first, each in the 5-bit digit code {pos_flag, bcd[3:0]}.
- Rebuilds the signed 6-bit value in sign / one's-complement-magnitude form: bit5 = sign; a negative value carries the inverted magnitude in bits 4:0.
- Valid/ready on both sides; one accumulated value is emitted per number.

Parameters:
W, 6, output value width including sign bit; magnitude limit MAG_MAX = 2^(W-1)-1 = 31
MAX_DIGITS, 3, maximum digit beats per number before overflow is flagged

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  digit beat valid
in_ready  output  1  block accepts a digit beat this cycle
in_digit  input  5  digit code: bit4 = pos_flag (1 = positive, 0 = negative), bits3:0 = BCD digit
in_first  input  1  beat is the most significant digit of a new number
in_last  input  1  beat is the final digit of the number
out_valid  output  1  encoded value available
out_ready  input  1  consumer takes the value
out_value  output  W  encoded value: {0, mag} when positive, {1, ~mag} when negative
out_err  output  1  number had an invalid digit, overflow or too many digits

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; acc=0, cnt=0, sign=0, err=0.
  - out_valid=0, out_value=0, out_err=0.
  - in_ready=1 from the first clk edge after release.
  - Reset during ACCUM or DONE discards the number.
- Beat acceptance: a beat is accepted when in_valid & in_ready at the rising clk edge.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE.
- IDLE:
  - An accepted beat with in_first=0 is dropped, with no state change.
  - An accepted beat with in_first=1 sets sign=~in_digit[4], acc=digit, cnt=1, err=0.
  - Next state is DONE if in_last=1, otherwise ACCUM.
- ACCUM:
  - Accepted beat with in_first=0: acc = sat(acc*10 + digit) and cnt=cnt+1. pos_flag is ignored on non-first beats.
  - Next state is DONE if in_last=1, otherwise stay in ACCUM.
  - Accepted beat with in_first=1: abandon the current number and restart exactly as from IDLE (in_first has priority).
- Arithmetic:
  - Compute in an internal width of at least W+4 bits.
  - Result > MAG_MAX: acc=MAG_MAX and err=1 (saturate).
  - BCD digit > 9: err=1 and acc unchanged for that beat.
  - cnt reaching MAX_DIGITS+1: err=1 and acc unchanged.
  - err stays set until the next number starts.
- DONE:
  - out_valid=1.
  - out_value = sign ? {1, ~acc[W-2:0]} : {0, acc[W-2:0]}.
  - out_err = err.
  - Outputs are registered and held stable while out_ready=0.
  - out_valid & out_ready moves the state to IDLE; out_valid=0 next cycle.
- Latency: out_valid rises on the clk edge that accepts the in_last beat, i.e. visible the cycle after that beat. Throughput is one number per (digits + 1) cycles with out_ready held high.
- Negative zero (pos_flag=0, all digits 0) → out_value = all ones (6'b111111), out_err=0.
- A single beat with in_first=1 and in_last=1 is a one-digit number.

Decomposition:
- Package digit_pkg:
  - state enum {IDLE, ACCUM, DONE}
  - MAG_MAX, BCD_MAX=9, DIGIT_CODE_W=5, POS_FLAG_BIT=4
- Sub-module digit_mac:
  - Combinational acc*10 + digit.
  - Saturates at MAG_MAX.
  - Raises ovf and bad_digit flags.
  - Instantiated once in digit_stream_encoder.

Test Plan:
1. Beats 5'b1_0010 (first), 5'b1_0111 (last), out_ready=1 → one cycle later out_valid=1, out_value=6'b011011 (+27), out_err=0.
2. Beats 5'b0_0001 (first), 5'b0_1001 (last) → out_value=6'b101100 (−19), out_err=0.
3. Beats +4 then +5 (45 > 31) → out_value=6'b011111, out_err=1; the next number +3 (single beat) → 6'b000011, out_err=0.
4. Beat 5'b1_1100 (first), then +1 (last) → out_err=1, out_value=6'b000001.
5. Backpressure:
   - Stimulus: after +27 completes, hold out_ready=0 for 5 cycles while driving in_valid with a new first beat.
   - Required: out_value/out_valid stable, in_ready=0, no beat consumed; on out_ready=1 the new beat is accepted the following cycle.
6. Restart and reset mid-number:
   - +1 (first), +2, then +7 with first & last → out_value=6'b000111.
   - Separately, assert rst_n=0 mid-ACCUM → all outputs 0 immediately.
   - After release, beat −0 (first & last) → out_value=6'b111111.
